// File: rtl/assoc_cache.sv
// Fully associative cache with LRU ordering by slot position (slot 0 = MRU).
// Reads allocate on miss; writes go through to memory and also allocate.
//
// state  | meaning
// IDLE   | waiting for a request; flush clears all entries here
// LOOKUP | tag compare against the latched address
// MEM    | backing-memory access held until mem_ack
// RESP   | one-cycle response pulse, statistics update
module assoc_cache #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CELL_CNT   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);
    localparam int IDX_W = (CELL_CNT > 1) ? $clog2(CELL_CNT) : 1;
    localparam logic [IDX_W-1:0] LRU_IDX = IDX_W'(CELL_CNT - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM, RESP} state_t;

    state_t                state, state_next;
    logic [CELL_CNT-1:0]   valid;
    logic [ADDR_WIDTH-1:0] tag  [CELL_CNT];
    logic [DATA_WIDTH-1:0] data [CELL_CNT];

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  hit_q;
    logic [IDX_W-1:0]      idx_q;

    logic                  lk_hit;
    logic [IDX_W-1:0]      lk_idx;
    logic                  upd;
    logic [IDX_W-1:0]      upd_src;
    logic [DATA_WIDTH-1:0] upd_data;

    // At most one valid entry can match, since only misses allocate.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < CELL_CNT; i++) begin
            if (valid[i] && tag[i] == lat_addr) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    // An update moves slot upd_src to slot 0 with new contents; an insert
    // is the same move taken from the LRU slot, which drops that entry.
    always_comb begin
        state_next = state;
        upd        = 1'b0;
        upd_src    = LRU_IDX;
        upd_data   = lat_wdata;
        case (state)
            IDLE: begin
                if (!flush && req_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (!lat_we && lk_hit) begin
                    state_next = RESP;
                    upd        = 1'b1;
                    upd_src    = lk_idx;
                    upd_data   = data[lk_idx];
                end else begin
                    state_next = MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_next = RESP;
                    upd        = 1'b1;
                    upd_src    = hit_q ? idx_q : LRU_IDX;
                    upd_data   = lat_we ? lat_wdata : mem_rdata;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (flush) begin
                    valid <= '0;
                end else if (req_valid) begin
                    lat_we    <= req_we;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                end
            end
            if (state == LOOKUP) begin
                hit_q    <= lk_hit;
                idx_q    <= lk_idx;
                resp_hit <= lk_hit;
            end
            if (upd) begin
                for (int i = CELL_CNT - 1; i > 0; i--) begin
                    if (IDX_W'(i) <= upd_src) begin
                        valid[i] <= valid[i-1];
                        tag[i]   <= tag[i-1];
                        data[i]  <= data[i-1];
                    end
                end
                valid[0]   <= 1'b1;
                tag[0]     <= lat_addr;
                data[0]    <= upd_data;
                resp_rdata <= upd_data;
            end
            if (state == RESP) begin
                if (resp_hit) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end

    assign req_ready  = (state == IDLE) && !flush;
    assign resp_valid = (state == RESP);
    assign mem_req    = (state == MEM);
    assign mem_we     = mem_req && lat_we;
    assign mem_addr   = mem_req ? lat_addr : '0;
    assign mem_wdata  = (mem_req && lat_we) ? lat_wdata : '0;
endmodule
